// File: rtl/load_store_unit.sv
// Load/store unit: RV32I B/H/W accesses over a req/ack data bus, with wait timeout and flush/kill.
// Optional feature macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of truncating the address.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        kill_q, kill_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        load_q, load_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_err_q, bus_err_d;

    logic        access_ok;
    logic        misalign_hit;
    logic        timeout;
    logic        is_byte;
    logic        is_half;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign access_ok = req_valid && (is_load || is_store) && !flush;
    assign is_byte   = (funct3[1:0] == 2'b00);
    assign is_half   = (funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_hit = (is_half && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign misalign_hit = 1'b0;
`endif

    assign timeout = (state_q == REQ) && !mem_ack && (wait_cnt_q == 8'(MAX_WAIT - 1));

    // Halfwords ignore addr[0] and words ignore addr[1:0]; the trap build never issues those cases.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        if (is_byte) begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        byte_sel = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        kill_d       = kill_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        load_d       = load_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        rdata_d      = 32'd0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access_ok) begin
                    stall = 1'b1;
                    if (misalign_hit) begin
                        state_d      = RESP;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        wait_cnt_d  = 8'd0;
                        kill_d      = 1'b0;
                        funct3_d    = funct3;
                        addr_lo_d   = addr[1:0];
                        load_d      = is_load;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !is_load;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_calc;
                        mem_wdata_d = is_load ? 32'd0 : wdata_calc;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                // A flushed access still finishes its bus handshake but never reports done.
                if (mem_ack || timeout) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_be_d    = 4'd0;
                    mem_wdata_d = 32'd0;
                    kill_d      = 1'b0;
                    if (kill_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        bus_err_d = !mem_ack;
                        rdata_d   = (mem_ack && load_q) ? load_ext : 32'd0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            kill_q       <= 1'b0;
            funct3_q     <= 3'd0;
            addr_lo_q    <= 2'd0;
            load_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            done_q       <= 1'b0;
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            kill_q       <= kill_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            load_q       <= load_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign done       = done_q;
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven spec vectors, hand sequences, randomized model checks.
// Follows LSU_MISALIGN_TRAP_EN so the reference model matches whichever build is simulated.
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          ack_at;
        int          flush_at;
        bit          exp_trap;
        bit          exp_done;
        bit          exp_bus_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .flush      (flush),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
    endtask

    // Transaction-level reference: expectations come from access size, lane offset and ack/flush timing.
    function automatic vec_t modelVec(bit ld, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                      logic [31:0] mrd, int ack_at, int flush_at);
        vec_t v;
        int size;
        int shift;
        int req_len;
        bit timed_out;
        bit killed;
        logic [31:0] val;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd;
        v.ack_at = ack_at; v.flush_at = flush_at;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        shift = (size == 1) ? int'(a[1:0]) : (size == 2) ? (a[1] ? 2 : 0) : 0;
        v.exp_trap = TRAP_EN && ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00));
        v.exp_be = (size == 4) ? 4'hF : (size == 2) ? (4'h3 << shift) : (4'h1 << shift);
        v.exp_wdata = ld ? 32'd0 : (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                      (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        req_len   = (ack_at <= MAX_WAIT) ? ack_at : MAX_WAIT;
        timed_out = ack_at > MAX_WAIT;
        killed    = !v.exp_trap && flush_at >= 1 && flush_at <= req_len;
        v.exp_done    = !killed;
        v.exp_bus_err = !v.exp_trap && !killed && timed_out;
        val = 32'd0;
        if (ld && !v.exp_trap && !timed_out) begin
            val = mrd >> (8 * shift);
            if (size == 1) begin
                val &= 32'hFF;
                if (!f3[2] && val[7]) val |= 32'hFFFF_FF00;
            end else if (size == 2) begin
                val &= 32'hFFFF;
                if (!f3[2] && val[15]) val |= 32'hFFFF_0000;
            end
        end
        v.exp_rdata = val;
        return v;
    endfunction

    function automatic vec_t mkVec(bit ld, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                   logic [31:0] mrd, int ack_at, int flush_at, bit e_done, bit e_berr,
                                   logic [31:0] e_rdata, logic [3:0] e_be, logic [31:0] e_wdata);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd;
        v.ack_at = ack_at; v.flush_at = flush_at; v.exp_trap = 1'b0;
        v.exp_done = e_done; v.exp_bus_err = e_berr; v.exp_rdata = e_rdata;
        v.exp_be = e_be; v.exp_wdata = e_wdata;
        return v;
    endfunction

    // Drives one access from IDLE through completion; scrambles inputs while busy to prove they are ignored.
    task automatic applyStimulus(input vec_t v, input string tag);
        int k;
        bit fin;
        req_valid = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
        addr = v.addr; wdata = v.wdata; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #1 checkOutput({tag, "_stall_accept"}, 32'(stall), 32'd1);
        tick();
        req_valid = 1'($urandom); is_load = 1'($urandom); is_store = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (v.exp_trap) begin
            req_valid = 1'b0;
            #1;
            checkOutput({tag, "_trap_req"}, 32'(mem_req), 32'd0);
        end else begin
            k = 1;
            fin = 1'b0;
            while (!fin) begin
                #1;
                checkOutput($sformatf("%s_req_c%0d", tag, k), 32'(mem_req), 32'd1);
                checkOutput($sformatf("%s_stall_c%0d", tag, k), 32'(stall), 32'd1);
                checkOutput($sformatf("%s_done_c%0d", tag, k), 32'(done), 32'd0);
                checkOutput({tag, "_we"}, 32'(mem_we), 32'(!v.ld));
                checkOutput({tag, "_maddr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                checkOutput({tag, "_be"}, 32'(mem_be), 32'(v.exp_be));
                if (!v.ld) checkOutput({tag, "_mwdata"}, mem_wdata, v.exp_wdata);
                mem_ack   = (k == v.ack_at);
                flush     = (k == v.flush_at);
                mem_rdata = mem_ack ? v.mrd : $urandom;
                tick();
                mem_ack = 1'b0;
                flush   = 1'b0;
                if (k == v.ack_at || k == MAX_WAIT) fin = 1'b1;
                else k++;
            end
            req_valid = 1'b0;
            #1;
        end
        checkOutput({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_stall_end"}, 32'(stall), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'(v.exp_done));
        if (v.exp_done) begin
            checkOutput({tag, "_rdata"}, rdata, v.exp_rdata);
            checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'(v.exp_bus_err));
            checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'(v.exp_trap));
            req_valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h0000_0F00;
        end
        tick();
        idleInputs();
        #1;
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_no_resp_accept"}, 32'(mem_req), 32'd0);
        tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rdata"}, rdata, 32'd0);
        checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [2:0] ld_codes[5];
        logic [2:0] st_codes[3];
        int sel;
        int ack_at;
        int flush_at;
        int req_len;

        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_codes = '{3'd0, 3'd1, 3'd2};

        // ld, st, f3, addr, wdata, mem_rdata, ack_at, flush_at, done, bus_err, rdata, be, wdata
        vecs.push_back(mkVec(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, 0, 1, 0, 32'hFFFF_FF80, 4'b1000, 32'h0));
        vecs.push_back(mkVec(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 0, 1, 0, 32'h0, 4'b1100, 32'hABCD_ABCD));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h1234_5678, 5, 0, 1, 0, 32'h1234_5678, 4'b1111, 32'h0));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 99, 0, 1, 1, 32'h0, 4'b1111, 32'h0));
        vecs.push_back(mkVec(1, 0, 3'b101, 32'h0000_0602, 32'h0, 32'h5555_AAAA, 3, 1, 0, 0, 32'h0, 4'b1100, 32'h0));
        vecs.push_back(mkVec(1, 0, 3'b100, 32'h0000_0701, 32'h0, 32'h0000_C300, 2, 0, 1, 0, 32'h0000_00C3, 4'b0010, 32'h0));
        vecs.push_back(mkVec(1, 0, 3'b001, 32'h0000_0802, 32'h0, 32'h8001_1234, 1, 0, 1, 0, 32'hFFFF_8001, 4'b1100, 32'h0));
        vecs.push_back(mkVec(0, 1, 3'b000, 32'h0000_0901, 32'hDEAD_BE5A, 32'h0, 1, 0, 1, 0, 32'h0, 4'b0010, 32'h5A5A_5A5A));
        vecs.push_back(mkVec(0, 1, 3'b010, 32'h0000_0A00, 32'hCAFE_F00D, 32'h0, 3, 0, 1, 0, 32'h0, 4'b1111, 32'hCAFE_F00D));
        vecs.push_back(mkVec(1, 0, 3'b101, 32'h0000_0B00, 32'h0, 32'hFFFF_9ABC, 1, 0, 1, 0, 32'h0000_9ABC, 4'b0011, 32'h0));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0000_0C00, 32'h0, 32'h1111_2222, 2, 2, 0, 0, 32'h0, 4'b1111, 32'h0));
        vecs.push_back(mkVec(1, 1, 3'b000, 32'h0000_0D02, 32'h0, 32'h007F_0000, 1, 0, 1, 0, 32'h0000_007F, 4'b0100, 32'h0));

        idleInputs();
        reset = 1'b1;
        tick();
        tick();
        #1 checkResetState("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Misaligned word and halfword: trap in the trap build, truncated lanes otherwise.
        applyStimulus(modelVec(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'hA1B2_C3D4, 1, 0), "lw_mis");
        applyStimulus(modelVec(1, 0, 3'b001, 32'h0000_0013, 32'h0, 32'h9876_0000, 2, 0), "lh_mis");
        applyStimulus(modelVec(0, 1, 3'b001, 32'h0000_0021, 32'h0000_1357, 32'h0, 1, 0), "sh_mis");

        // flush while idle blocks acceptance
        req_valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h100; flush = 1'b1;
        #1 checkOutput("idle_flush_stall", 32'(stall), 32'd0);
        tick();
        idleInputs();
        #1 checkOutput("idle_flush_req", 32'(mem_req), 32'd0);
        tick();

        // req_valid without load or store is not an access
        req_valid = 1'b1; funct3 = 3'd2; addr = 32'h200;
        #1 checkOutput("notype_stall", 32'(stall), 32'd0);
        tick();
        idleInputs();
        #1 checkOutput("notype_req", 32'(mem_req), 32'd0);
        tick();

        // reset mid-REQ drops mem_req, and a late ack in IDLE is ignored
        req_valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h0000_0440;
        tick();
        idleInputs();
        #1 checkOutput("rstreq_up", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 checkResetState("rstreq");
        mem_ack = 1'b1; mem_rdata = 32'hFEED_BEEF;
        tick();
        idleInputs();
        #1;
        checkOutput("late_ack_done", 32'(done), 32'd0);
        checkOutput("late_ack_req", 32'(mem_req), 32'd0);
        checkOutput("late_ack_rdata", rdata, 32'd0);
        tick();

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            ack_at = ($urandom_range(0, 7) == 0) ? MAX_WAIT + 1 : $urandom_range(1, 6);
            req_len = (ack_at <= MAX_WAIT) ? ack_at : MAX_WAIT;
            flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (req_len < 6) ? req_len : 6) : 0;
            if (sel == 1) begin
                v = modelVec(0, 1, st_codes[$urandom_range(0, 2)], $urandom, $urandom, 32'h0, ack_at, flush_at);
            end else begin
                v = modelVec(1, (sel == 2), ld_codes[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                             ack_at, flush_at);
            end
            applyStimulus(v, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
